// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter time-sharing one ripple-carry adder among NUM_REQ requesters.
// Operands are held in registers while the adder settles for SETTLE_CYCLES cycles.

module ripple_carry_adder_27bit #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0] i_term1,
  input  logic [WIDTH-1:0] i_term2,
  output logic [WIDTH:0]   o_sum
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar b = 0; b < WIDTH; b++) begin : g_fa
    assign o_sum[b]     = i_term1[b] ^ i_term2[b] ^ carry[b];
    assign carry[b + 1] = (i_term1[b] & i_term2[b]) | (i_term1[b] & carry[b]) |
                          (i_term2[b] & carry[b]);
  end

  assign o_sum[WIDTH] = carry[WIDTH];
endmodule

// state  | meaning
// IDLE   | arbitrating; o_req_ready shows the round-robin winner
// SETTLE | operands held on the adder, settle counter running down
// RESP   | result presented until the consumer takes it
module rca_share_arbiter #(
  parameter int WIDTH         = 27,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_term1,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_term2,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [WIDTH:0]             o_rsp_result,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic                       o_busy
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDW-1:0]  LAST_ID    = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               found;
  logic [IDW:0]       idx;
  logic [WIDTH-1:0]   sel1, sel2;
  logic [WIDTH:0]     sum_w;
  logic               accept;

  ripple_carry_adder_27bit #(.WIDTH(WIDTH)) u_adder (
    .i_term1 (op1_q),
    .i_term2 (op2_q),
    .o_sum   (sum_w)
  );

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
      if (idx >= (IDW + 1)'(NUM_REQ)) idx = idx - (IDW + 1)'(NUM_REQ);
      if (!found && i_req_valid[idx[IDW-1:0]]) begin
        found                 = 1'b1;
        grant[idx[IDW-1:0]]   = 1'b1;
        grant_id              = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel1 = i_req_term1[k*WIDTH +: WIDTH];
        sel2 = i_req_term2[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_req_ready = (state_q == ST_IDLE && !i_rst) ? grant : '0;
  assign accept      = |o_req_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op1_d    = sel1;
          op2_d    = sel2;
          id_d     = grant_id;
          rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          cnt_d    = CNT_RELOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          result_d    = sum_w;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_id     = id_q;
  assign o_busy       = busy_q;
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Scoreboard bench for rca_share_arbiter: default instance plus two NUM_REQ=2 instances
// with SETTLE_CYCLES of 1 and 5.
module tb_rca_share_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [107:0] term1, term2;
  logic         rsp_valid, rsp_ready, busy;
  logic [27:0]  rsp_result;
  logic [1:0]   rsp_id;

  rca_share_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_term1(term1), .i_req_term2(term2), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result), .o_rsp_id(rsp_id), .o_busy(busy)
  );

  // sweep instances: index 0 -> SETTLE_CYCLES=1, index 1 -> SETTLE_CYCLES=5
  logic [1:0]   sw_valid [2];
  logic [1:0]   sw_ready [2];
  logic         sw_rsp_valid [2];
  logic [27:0]  sw_result [2];
  logic [0:0]   sw_id [2];
  logic         sw_busy [2];
  logic [53:0]  sw_t1, sw_t2;

  rca_share_arbiter #(.WIDTH(27), .NUM_REQ(2), .SETTLE_CYCLES(1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(sw_valid[0]), .o_req_ready(sw_ready[0]),
    .i_req_term1(sw_t1), .i_req_term2(sw_t2), .o_rsp_valid(sw_rsp_valid[0]),
    .i_rsp_ready(1'b1), .o_rsp_result(sw_result[0]), .o_rsp_id(sw_id[0]), .o_busy(sw_busy[0])
  );
  rca_share_arbiter #(.WIDTH(27), .NUM_REQ(2), .SETTLE_CYCLES(5)) dut_s5 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(sw_valid[1]), .o_req_ready(sw_ready[1]),
    .i_req_term1(sw_t1), .i_req_term2(sw_t2), .o_rsp_valid(sw_rsp_valid[1]),
    .i_rsp_ready(1'b1), .o_rsp_result(sw_result[1]), .o_rsp_id(sw_id[1]), .o_busy(sw_busy[1])
  );

  logic [29:0]  exp_q [$];      // {id, result}
  int           acc_log [$];
  int           hs_log [$];
  logic [28:0]  sw_exp [4];     // {id, result}, same sequence for both sweep instances
  int           sw_acc_cyc [2][8];
  int           sw_rsp_cyc [2][8];
  int           sw_nacc [2];
  int           sw_nrsp [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // monitor / scoreboard for the default instance
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [27:0] prev_result = '0;
  logic [1:0]  prev_id = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) acc_log.push_back(cyc);
      if (rsp_valid) begin
        check("req_ready_during_rsp", 64'(req_ready), 64'(0));
        if (!prev_valid) begin
          if (acc_log.size() > 0) check("rsp_latency", 64'(cyc - acc_log[$]), 64'(3));
        end else if (!prev_ready) begin
          check("hold_result", 64'(rsp_result), 64'(prev_result));
          check("hold_id", 64'(rsp_id), 64'(prev_id));
        end
        if (rsp_ready) begin
          hs_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp_id", 64'(rsp_id), 64'(4));
          end else begin
            logic [29:0] e;
            e = exp_q.pop_front();
            check("rsp_result", 64'(rsp_result), 64'(e[27:0]));
            check("rsp_id", 64'(rsp_id), 64'(e[29:28]));
          end
        end
      end
      prev_valid  = rsp_valid;
      prev_ready  = rsp_ready;
      prev_result = rsp_result;
      prev_id     = rsp_id;
    end
  end

  // monitor for the sweep instances (i_rsp_ready tied high: every valid cycle is a handshake)
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (|(sw_valid[d] & sw_ready[d]) && sw_nacc[d] < 8) begin
          sw_acc_cyc[d][sw_nacc[d]] = cyc;
          sw_nacc[d]++;
        end
        if (sw_rsp_valid[d] && sw_nrsp[d] < 8) begin
          sw_rsp_cyc[d][sw_nrsp[d]] = cyc;
          if (sw_nrsp[d] < 4) begin
            check("sw_result", 64'(sw_result[d]), 64'(sw_exp[sw_nrsp[d]][27:0]));
            check("sw_id", 64'(sw_id[d]), 64'(sw_exp[sw_nrsp[d]][28]));
          end
          sw_nrsp[d]++;
        end
      end
    end
  end

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_log.size() < target && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (acc_log.size() < target) fail_timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0 || rsp_valid) fail_timeout(name);
  endtask

  task automatic set_terms(input int k, input logic [26:0] a, input logic [26:0] b);
    term1[k*27 +: 27] = a;
    term2[k*27 +: 27] = b;
  endtask

  task automatic issue(input int k, input logic [26:0] a, input logic [26:0] b,
                       input logic [27:0] sum, input bit push);
    int base;
    if (push) exp_q.push_back({2'(k), sum});
    set_terms(k, a, b);
    base = acc_log.size();
    req_valid[k] = 1'b1;
    wait_acc(base + 1, "accept_wait");
    req_valid[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    rst = 1'b1; req_valid = '0; term1 = '0; term2 = '0; rsp_ready = 1'b1;
    sw_valid[0] = '0; sw_valid[1] = '0; sw_t1 = '0; sw_t2 = '0;
    sw_nacc[0] = 0; sw_nacc[1] = 0; sw_nrsp[0] = 0; sw_nrsp[1] = 0;
    sw_exp[0] = {1'b0, 28'h0000007};
    sw_exp[1] = {1'b1, 28'hFFFFFFE};
    sw_exp[2] = {1'b0, 28'h0000007};
    sw_exp[3] = {1'b1, 28'hFFFFFFE};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_result", 64'(rsp_result), 64'(0));
    check("reset_id", 64'(rsp_id), 64'(0));
    @(posedge clk); #1;

    // single op: requester 2, carry ripples through every bit
    issue(2, 27'h7FFFFFF, 27'h0000001, 28'h8000000, 1'b1);
    check("busy_after_accept", 64'(busy), 64'(1));
    wait_idle("single_op");

    // backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    issue(0, 27'h0123456, 27'h0654321, 28'h0777777, 1'b1);
    exp_q.push_back({2'd1, 28'h0BCDF00});
    set_terms(1, 27'h0ABCDEF, 27'h0111111);
    req_valid[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) fail_timeout("bp_rsp_wait");
    base = acc_log.size();
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_accept", 64'(acc_log.size()), 64'(base));
    check("bp_still_valid", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    wait_acc(base + 1, "bp_accept_wait");
    req_valid[1] = 1'b0;
    if (acc_log.size() > base && hs_log.size() > 0)
      check("bp_accept_after_hs", 64'(acc_log[$] - hs_log[$]), 64'(1));
    wait_idle("backpressure");

    // reset mid-SETTLE: in-flight op from requester 1 must vanish
    issue(1, 27'h0000005, 27'h0000006, 28'h000000B, 1'b0);
    rst = 1'b1;
    set_terms(0, 27'h0000100, 27'h0000200);
    set_terms(3, 27'h1000000, 27'h1000000);
    req_valid = 4'b1001;
    @(negedge clk);
    check("ready_in_reset", 64'(req_ready), 64'(0));
    exp_q.push_back({2'd0, 28'h0000300});
    exp_q.push_back({2'd3, 28'h2000000});
    base = acc_log.size();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_reset_result", 64'(rsp_result), 64'(0));
    check("post_reset_id", 64'(rsp_id), 64'(0));
    check("post_reset_busy", 64'(busy), 64'(0));
    check("post_reset_grant", 64'(req_ready), 64'(4'b0001));
    wait_acc(base + 1, "rst_acc0");
    req_valid[0] = 1'b0;
    wait_acc(base + 2, "rst_acc3");
    req_valid[3] = 1'b0;
    wait_idle("reset_mid_settle");

    // round robin, all four continuously valid
    set_terms(0, 27'h0000010, 27'h0000020);
    set_terms(1, 27'h1234567, 27'h0111111);
    set_terms(2, 27'h4000000, 27'h4000000);
    set_terms(3, 27'h7FFFFF0, 27'h0000020);
    exp_q.push_back({2'd0, 28'h0000030});
    exp_q.push_back({2'd1, 28'h1345678});
    exp_q.push_back({2'd2, 28'h8000000});
    exp_q.push_back({2'd3, 28'h8000010});
    exp_q.push_back({2'd0, 28'h0000030});
    base = acc_log.size();
    req_valid = 4'hF;
    wait_acc(base + 5, "rr_accepts");
    req_valid = '0;
    if (acc_log.size() >= base + 5)
      for (int i = 1; i < 5; i++)
        check("rr_spacing", 64'(acc_log[base + i] - acc_log[base + i - 1]), 64'(4));
    wait_idle("round_robin");

    // boundary operands
    issue(0, 27'h0000000, 27'h0000000, 28'h0000000, 1'b1);
    wait_idle("bnd_zero");
    issue(3, 27'h7FFFFFF, 27'h7FFFFFF, 28'hFFFFFFE, 1'b1);
    wait_idle("bnd_max");
    issue(1, 27'h5555555, 27'h2AAAAAA, 28'h7FFFFFF, 1'b1);
    wait_idle("bnd_alt");

    // parameter sweep: NUM_REQ=2, SETTLE_CYCLES 1 and 5
    sw_t1 = {27'h7FFFFFF, 27'h0000003};
    sw_t2 = {27'h7FFFFFF, 27'h0000004};
    for (int d = 0; d < 2; d++) begin
      sw_valid[d] = 2'b11;
      n = 0;
      while (sw_nacc[d] < 4 && n < 100) begin @(posedge clk); #1; n++; end
      sw_valid[d] = 2'b00;
      if (sw_nacc[d] < 4) fail_timeout("sw_accepts");
      n = 0;
      while (sw_nrsp[d] < 4 && n < 100) begin @(posedge clk); #1; n++; end
      if (sw_nrsp[d] < 4) fail_timeout("sw_responses");
      repeat (2) @(posedge clk);
      #1;
      check("sw_total_rsp", 64'(sw_nrsp[d]), 64'(4));
      check("sw_busy_idle", 64'(sw_busy[d]), 64'(0));
      for (int i = 0; i < 4; i++)
        if (i < sw_nacc[d] && i < sw_nrsp[d])
          check("sw_latency", 64'(sw_rsp_cyc[d][i] - sw_acc_cyc[d][i]), 64'((d == 0) ? 2 : 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
